// File: rtl/ul4_arbiter.sv
// Two-requester arbiter for the shared 4-bit logic unit. Results come out two edges after
// acceptance; a response is held while res_ready=0 and both requesters stall until it drains.

module ul4 (
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  always_comb begin
    case (op)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b;
      default: y = ~a;
    endcase
  end
endmodule

module ul4_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_id,
  output logic [3:0] res_out,
  output logic       res_zero,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       id;
  } req_t;

  state_t     state, state_nxt;
  req_t       req_q;
  logic       last_id;
  logic       grant;
  logic       xfer;
  logic [3:0] ul4_y;

  // Round-robin favours whoever did not finish last; fixed priority always favours req0.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid)
      grant = (PRIO_MODE != 0) ? 1'b0 : ~last_id;
    else if (req1_valid)
      grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign xfer       = req0_ready || req1_ready;
  assign res_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  ul4 u_ul4 (
    .op (req_q.op),
    .a  (req_q.a),
    .b  (req_q.b),
    .y  (ul4_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= '0;
      res_out  <= 4'd0;
      res_zero <= 1'b0;
      res_id   <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (xfer)
        req_q <= grant ? {req1_op, req1_a, req1_b, 1'b1}
                       : {req0_op, req0_a, req0_b, 1'b0};
      if (state == EXEC) begin
        res_out  <= ul4_y;
        res_zero <= (ul4_y == 4'd0);
        res_id   <= req_q.id;
      end
      // Fairness history advances only once the consumer has taken the result.
      if (state == RESP && res_ready)
        last_id <= res_id;
    end
  end

endmodule
